// File: rtl/cam_bringup_ctrl.sv
// cam_bringup_ctrl: OV5640 power-up / bring-up sequencer and supervisor.
//   Drives the sensor power-down and reset pins with timed gaps, releases the
//   I2C configuration engine, skips the first unstable frames, then enables
//   the video path. A config failure or a lost vsync stream re-runs the whole
//   power cycle; repeated failures latch FAULT until rst.
// Ports:
//   clk, rst        video_clk and async active-high reset
//   restart         one-cycle request to re-run bring-up (ignored in FAULT)
//   cmos_vsync      raw sensor vsync, asynchronous to clk
//   cfg_done/error  i2c_config status levels
//   cfg_rst         active-high reset to i2c_config
//   cmos_pwdn       sensor power-down
//   cmos_rst_n      sensor reset, active-low
//   video_en        frame write / display enable
//   fault           sticky failure flag
//   state_o         current state encoding
//   retry_cnt       failed attempts in the current bring-up
module cam_bringup_ctrl #(
    parameter int unsigned T_PWDN_CYC      = 500000,
    parameter int unsigned T_RST_CYC       = 500000,
    parameter int unsigned T_SETTLE_CYC    = 1000000,
    parameter int unsigned CFG_TIMEOUT_CYC = 50000000,
    parameter int unsigned MAX_RETRY       = 3,
    parameter int unsigned SKIP_FRAMES     = 4,
    parameter int unsigned VS_WDT_CYC      = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    input  logic       cmos_vsync,
    input  logic       cfg_done,
    input  logic       cfg_error,
    output logic       cfg_rst,
    output logic       cmos_pwdn,
    output logic       cmos_rst_n,
    output logic       video_en,
    output logic       fault,
    output logic [2:0] state_o,
    output logic [1:0] retry_cnt
);

    typedef enum logic [2:0] {
        PWDN   = 3'd0,
        RST    = 3'd1,
        SETTLE = 3'd2,
        CONFIG = 3'd3,
        SKIP   = 3'd4,
        RUN    = 3'd5,
        FAULT  = 3'd6
    } state_t;

    state_t      state, nx;
    logic [31:0] cnt;       // duration in current state
    logic [31:0] wdt;       // cycles since last vs_rise or state entry
    logic [15:0] skip_cnt;  // vsync edges seen in SKIP
    logic        vs_meta, vs_sync1, vs_sync2_d;
    logic        vs_rise, wdt_exp, fail, enter, do_restart;
    logic [1:0]  retry_inc;

    // Two-flop synchronizer plus one delay flop for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_meta    <= 1'b0;
            vs_sync1   <= 1'b0;
            vs_sync2_d <= 1'b0;
        end else begin
            vs_meta    <= cmos_vsync;
            vs_sync1   <= vs_meta;
            vs_sync2_d <= vs_sync1;
        end
    end

    assign vs_rise    = vs_sync1 & ~vs_sync2_d;
    // A vsync edge landing on the expiry cycle keeps the stream alive.
    assign wdt_exp    = (wdt == 32'(VS_WDT_CYC - 1)) && !vs_rise;
    assign do_restart = restart && (state != FAULT);
    assign retry_inc  = (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;

    always_comb begin
        nx   = state;
        fail = 1'b0;
        if (do_restart) begin
            nx = PWDN;
        end else begin
            case (state)
                PWDN:   if (cnt == 32'(T_PWDN_CYC - 1))   nx = RST;
                RST:    if (cnt == 32'(T_RST_CYC - 1))    nx = SETTLE;
                SETTLE: if (cnt == 32'(T_SETTLE_CYC - 1)) nx = CONFIG;
                CONFIG: begin
                    // error wins over a simultaneous done
                    if (cfg_error)                                fail = 1'b1;
                    else if (cfg_done)                            nx   = SKIP;
                    else if (cnt == 32'(CFG_TIMEOUT_CYC - 1))     fail = 1'b1;
                end
                SKIP: begin
                    if (vs_rise && skip_cnt == 16'(SKIP_FRAMES - 1)) nx   = RUN;
                    else if (wdt_exp)                                fail = 1'b1;
                end
                RUN:     if (wdt_exp) nx = PWDN;
                default: nx = FAULT;
            endcase
            if (fail)
                nx = (retry_inc == 2'(MAX_RETRY)) ? FAULT : PWDN;
        end
        // restart into PWDN from PWDN still counts as a fresh entry
        enter = do_restart || (nx != state);
    end

    // Outputs decode the next state so they change on the transition edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= PWDN;
            cnt        <= '0;
            wdt        <= '0;
            skip_cnt   <= '0;
            retry_cnt  <= '0;
            cmos_pwdn  <= 1'b1;
            cmos_rst_n <= 1'b0;
            cfg_rst    <= 1'b1;
            video_en   <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state    <= nx;
            cnt      <= enter ? '0 : cnt + 32'd1;
            wdt      <= (enter || vs_rise) ? '0 : wdt + 32'd1;
            skip_cnt <= enter ? '0 :
                        (vs_rise && state == SKIP) ? skip_cnt + 16'd1 : skip_cnt;

            if (do_restart)                     retry_cnt <= '0;
            else if (fail)                      retry_cnt <= retry_inc;
            else if (nx == RUN && state != RUN) retry_cnt <= '0;

            cmos_pwdn  <= (nx == PWDN) || (nx == FAULT);
            cmos_rst_n <= (nx == SETTLE) || (nx == CONFIG) || (nx == SKIP) || (nx == RUN);
            cfg_rst    <= (nx == PWDN) || (nx == RST) || (nx == SETTLE) || (nx == FAULT);
            video_en   <= (nx == RUN);
            fault      <= (nx == FAULT);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_cam_bringup_ctrl.sv
// Directed bench for cam_bringup_ctrl with shortened timing parameters.
// Cycle k is the clk period following the k-th posedge after rst release;
// outputs are sampled at the negedge inside that period and inputs are
// driven right after that sample.
module tb_cam_bringup_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       restart = 1'b0;
    logic       cmos_vsync = 1'b0;
    logic       cfg_done = 1'b0;
    logic       cfg_error = 1'b0;
    logic       cfg_rst, cmos_pwdn, cmos_rst_n, video_en, fault;
    logic [2:0] state_o;
    logic [1:0] retry_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;
    bit vs_en   = 1'b0;

    cam_bringup_ctrl #(
        .T_PWDN_CYC(4), .T_RST_CYC(4), .T_SETTLE_CYC(8), .CFG_TIMEOUT_CYC(50),
        .MAX_RETRY(2), .SKIP_FRAMES(2), .VS_WDT_CYC(100)
    ) dut (
        .clk(clk), .rst(rst), .restart(restart), .cmos_vsync(cmos_vsync),
        .cfg_done(cfg_done), .cfg_error(cfg_error), .cfg_rst(cfg_rst),
        .cmos_pwdn(cmos_pwdn), .cmos_rst_n(cmos_rst_n), .video_en(video_en),
        .fault(fault), .state_o(state_o), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // vsync toggles every 40 cycles: high on cycles where (cyc/40) is odd
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        cmos_vsync = vs_en && (((cyc / 40) % 2) == 1);
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        restart = 1'b0; cfg_done = 1'b0; cfg_error = 1'b0;
        vs_en = 1'b0; cmos_vsync = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        // ---- reset values ----
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state_o), 0);
        chk("rst_pwdn", 32'(cmos_pwdn), 1);
        chk("rst_rstn", 32'(cmos_rst_n), 0);
        chk("rst_cfgrst", 32'(cfg_rst), 1);
        chk("rst_video", 32'(video_en), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_retry", 32'(retry_cnt), 0);

        // ---- nominal bring-up, then stream loss and recovery ----
        do_reset();
        vs_en = 1'b1;
        run_to(3);   chk("nom_pwdn_c3", 32'(cmos_pwdn), 1);
        run_to(4);   chk("nom_pwdn_c4", 32'(cmos_pwdn), 0);
                     chk("nom_state_c4", 32'(state_o), 1);
        run_to(7);   chk("nom_rstn_c7", 32'(cmos_rst_n), 0);
        run_to(8);   chk("nom_rstn_c8", 32'(cmos_rst_n), 1);
        run_to(15);  chk("nom_cfgrst_c15", 32'(cfg_rst), 1);
        run_to(16);  chk("nom_cfgrst_c16", 32'(cfg_rst), 0);
                     chk("nom_state_c16", 32'(state_o), 3);
        run_to(30);  cfg_done = 1'b1;
        run_to(31);  chk("nom_state_c31", 32'(state_o), 4);
        cfg_done = 1'b0;
        // pin rises at 40 and 120; second vs_rise seen in cycle 122
        run_to(122); chk("nom_video_c122", 32'(video_en), 0);
                     chk("nom_skip_c122", 32'(state_o), 4);
        run_to(123); chk("nom_video_c123", 32'(video_en), 1);
                     chk("nom_run_c123", 32'(state_o), 5);
                     chk("nom_retry_c123", 32'(retry_cnt), 0);
        run_to(299); chk("nom_video_c299", 32'(video_en), 1);
        // last pin rise at 280 -> vs_rise in 282; 100 quiet cycles from 283
        vs_en = 1'b0; cmos_vsync = 1'b0;
        run_to(382); chk("loss_video_c382", 32'(video_en), 1);
        run_to(383); chk("loss_video_c383", 32'(video_en), 0);
                     chk("loss_state_c383", 32'(state_o), 0);
                     chk("loss_retry_c383", 32'(retry_cnt), 0);
        // resume: CONFIG at 399, SKIP at 400, pin rises 440/520 -> RUN at 523
        vs_en = 1'b1; cfg_done = 1'b1;
        cmos_vsync = (((cyc / 40) % 2) == 1);
        run_to(400); chk("res_state_c400", 32'(state_o), 4);
        run_to(522); chk("res_state_c522", 32'(state_o), 4);
        run_to(523); chk("res_state_c523", 32'(state_o), 5);
                     chk("res_video_c523", 32'(video_en), 1);

        // ---- config error twice -> FAULT ----
        do_reset();
        cfg_error = 1'b1;
        run_to(16);  chk("err1_state_c16", 32'(state_o), 3);
        run_to(17);  chk("err1_state_c17", 32'(state_o), 0);
                     chk("err1_retry_c17", 32'(retry_cnt), 1);
                     chk("err1_pwdn_c17", 32'(cmos_pwdn), 1);
        run_to(21);  chk("err1_pwdn_c21", 32'(cmos_pwdn), 0);
        run_to(33);  chk("err2_state_c33", 32'(state_o), 3);
        run_to(34);  chk("err2_state_c34", 32'(state_o), 6);
                     chk("err2_fault_c34", 32'(fault), 1);
                     chk("err2_retry_c34", 32'(retry_cnt), 2);
                     chk("err2_pwdn_c34", 32'(cmos_pwdn), 1);
                     chk("err2_cfgrst_c34", 32'(cfg_rst), 1);
        run_to(40);  restart = 1'b1;
        run_to(41);  restart = 1'b0;
                     chk("fault_restart_c41", 32'(state_o), 6);
        run_to(60);  chk("fault_hold_c60", 32'(state_o), 6);
                     chk("fault_pwdn_c60", 32'(cmos_pwdn), 1);
                     chk("fault_video_c60", 32'(video_en), 0);

        // ---- config timeout: CONFIG occupies cycles 16..65 ----
        do_reset();
        run_to(65);  chk("tmo_state_c65", 32'(state_o), 3);
        run_to(66);  chk("tmo_state_c66", 32'(state_o), 0);
                     chk("tmo_retry_c66", 32'(retry_cnt), 1);

        // ---- done and error together -> error ----
        do_reset();
        cfg_done = 1'b1; cfg_error = 1'b1;
        run_to(17);  chk("both_state_c17", 32'(state_o), 0);
                     chk("both_retry_c17", 32'(retry_cnt), 1);

        // ---- restart during SETTLE ----
        do_reset();
        run_to(10);  chk("rs_state_c10", 32'(state_o), 2);
        restart = 1'b1;
        run_to(11);  restart = 1'b0;
                     chk("rs_state_c11", 32'(state_o), 0);
                     chk("rs_pwdn_c11", 32'(cmos_pwdn), 1);
                     chk("rs_rstn_c11", 32'(cmos_rst_n), 0);
        run_to(14);  chk("rs_state_c14", 32'(state_o), 0);
        run_to(15);  chk("rs_state_c15", 32'(state_o), 1);
                     chk("rs_pwdn_c15", 32'(cmos_pwdn), 0);

        // ---- async rst mid-CONFIG, between clock edges ----
        do_reset();
        run_to(20);  chk("ar_state_c20", 32'(state_o), 3);
                     chk("ar_cfgrst_c20", 32'(cfg_rst), 0);
        #1 rst = 1'b1;
        #1;
        chk("ar_state", 32'(state_o), 0);
        chk("ar_cfgrst", 32'(cfg_rst), 1);
        chk("ar_pwdn", 32'(cmos_pwdn), 1);
        chk("ar_rstn", 32'(cmos_rst_n), 0);
        chk("ar_retry", 32'(retry_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
